// File: rtl/booth_mul_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle multiplier.
// One operation in flight at a time; a hung multiplier is answered with an error after a timeout.
module booth_mul_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        resp0_valid,
    output logic        resp1_valid,
    input  logic        resp0_ready,
    input  logic        resp1_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [15:0] mul_in1,
    output logic [15:0] mul_in2,
    output logic        mul_start,
    input  logic [31:0] mul_out,
    input  logic        mul_done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic        done_q;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic grant0, grant1, done_edge, timeout, resp_taken;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b1 & 1'b0;
        if (state_q == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = !ptr_q;
                grant1 = ptr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // Only a fresh rising edge counts, so a done level held over from the previous operation is ignored.
    assign done_edge  = mul_done && !done_q;
    assign timeout    = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign resp_taken = owner_q ? resp1_ready : resp0_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                if (done_edge) begin
                    data_d  = mul_out;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timeout) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (resp_taken) begin
                    ptr_d   = !owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            done_q  <= mul_done;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign mul_start   = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign resp0_valid = (state_q == RESP) && !owner_q;
    assign resp1_valid = (state_q == RESP) && owner_q;
    assign resp_data   = data_q;
    assign resp_err    = err_q;
    assign mul_in1     = a_q;
    assign mul_in2     = b_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Randomized bench for booth_mul_arbiter: a behavioural multiplier plus a transaction-level
// model of grant order, product, latency and timeout.
module tb_booth_mul_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [15:0] mul_in1, mul_in2;
    logic        mul_start;
    logic [31:0] mul_out;
    logic        mul_done;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          prio;

    // multiplier behaviour knobs
    int unsigned m_lat;
    bit          m_tie_low;
    bit          m_stale;
    int unsigned m_cnt;
    bit          m_pend;
    logic [31:0] m_prod;

    booth_mul_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_start(mul_start),
        .mul_out(mul_out), .mul_done(mul_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Done rises m_lat cycles after the start edge and stays high until the next start;
    // in stale mode the old level survives the start and drops before the fresh rise.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend   <= 1'b0;
            mul_done <= 1'b0;
            mul_out  <= '0;
            m_cnt    <= 0;
            m_prod   <= '0;
        end else if (mul_start) begin
            m_prod <= {{16{mul_in1[15]}}, mul_in1} * {{16{mul_in2[15]}}, mul_in2};
            m_cnt  <= m_lat;
            m_pend <= 1'b1;
            if (!m_stale) mul_done <= 1'b0;
        end else if (m_pend) begin
            if (m_cnt == 0) begin
                m_pend <= 1'b0;
                if (!m_tie_low) begin
                    mul_done <= 1'b1;
                    mul_out  <= m_prod;
                end
            end else begin
                if (m_cnt == 2) mul_done <= 1'b0;
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_start"}, 32'(mul_start), 32'd0);
        check_eq({tag, "_rv0"}, 32'(resp0_valid), 32'd0);
        check_eq({tag, "_rv1"}, 32'(resp1_valid), 32'd0);
        check_eq({tag, "_rdy"}, 32'({req0_ready, req1_ready}), 32'd0);
        check_eq({tag, "_data"}, resp_data, 32'd0);
        check_eq({tag, "_err"}, 32'(resp_err), 32'd0);
        check_eq({tag, "_in1"}, 32'(mul_in1), 32'd0);
        check_eq({tag, "_in2"}, 32'(mul_in2), 32'd0);
    endtask

    task automatic run_op(input bit v0, input bit v1,
                          input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1,
                          input int unsigned lat, input bit tie_low, input bit stale,
                          input int unsigned hold);
        bit          k;
        logic [15:0] ea, eb;
        logic [31:0] exp_data;
        bit          exp_err;
        int unsigned waits, exp_waits;
        m_lat     = lat;
        m_tie_low = tie_low;
        m_stale   = stale;
        k         = (v0 && v1) ? prio : v1;
        ea        = k ? a1 : a0;
        eb        = k ? b1 : b0;
        exp_waits = tie_low ? TO + 1 : ((lat + 3 < TO + 1) ? lat + 3 : TO + 1);
        exp_err   = tie_low || (lat + 3 > TO + 1);
        exp_data  = exp_err ? 32'd0 : {{16{ea[15]}}, ea} * {{16{eb[15]}}, eb};

        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        #1;
        check_eq("grant0", 32'(req0_ready), 32'(v0 && !k));
        check_eq("grant1", 32'(req1_ready), 32'(k));
        check_eq("idle_busy", 32'(busy), 32'd0);

        @(negedge clk);
        req0_a = 16'($urandom()); req1_a = 16'($urandom());
        check_eq("start_pulse", 32'(mul_start), 32'd1);
        check_eq("start_in1", 32'(mul_in1), 32'(ea));
        check_eq("start_in2", 32'(mul_in2), 32'(eb));
        check_eq("start_rdy", 32'({req0_ready, req1_ready}), 32'd0);

        waits = 0;
        for (int i = 1; i <= int'(TO) + 20; i++) begin
            @(negedge clk);
            req0_b = 16'($urandom()); req1_b = 16'($urandom());
            #1;
            if (resp0_valid || resp1_valid) begin
                waits = i;
                break;
            end
            check_eq("busy_rdy", 32'({req0_ready, req1_ready, mul_start}), 32'd0);
            check_eq("busy_in", {mul_in1, mul_in2}, {ea, eb});
        end
        check_eq("latency", waits, exp_waits);
        if (waits == 0) return;
        check_eq("resp_owner", 32'({resp1_valid, resp0_valid}), k ? 32'd2 : 32'd1);
        check_eq("resp_data", resp_data, exp_data);
        check_eq("resp_err", 32'(resp_err), 32'(exp_err));

        for (int i = 0; i < int'(hold); i++) begin
            if (k) resp0_ready = 1'b1; else resp1_ready = 1'b1;
            @(negedge clk);
            resp0_ready = 1'b0; resp1_ready = 1'b0;
            #1;
            check_eq("hold_owner", 32'({resp1_valid, resp0_valid}), k ? 32'd2 : 32'd1);
            check_eq("hold_data", resp_data, exp_data);
            check_eq("hold_err", 32'(resp_err), 32'(exp_err));
            check_eq("hold_rdy", 32'({req0_ready, req1_ready}), 32'd0);
            check_eq("hold_in", {mul_in1, mul_in2}, {ea, eb});
        end

        if (k) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        #1;
        check_eq("taken_busy", 32'(busy), 32'd0);
        check_eq("taken_rv", 32'({resp0_valid, resp1_valid}), 32'd0);
        prio = !k;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        m_lat = 2; m_tie_low = 0; m_stale = 0;
        prio = 0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // single request 5 x -3
        run_op(1, 0, 16'd5, 16'(-3), 16'd0, 16'd0, 2, 0, 0, 0);

        // simultaneous requests right after reset
        @(negedge clk); rst = 1'b1; #1; rst = 1'b0; prio = 0;
        run_op(1, 1, 16'h8000, 16'hFFFF, 16'd32767, 16'd2, 1, 0, 0, 0);
        run_op(1, 1, 16'h8000, 16'hFFFF, 16'd32767, 16'd2, 3, 0, 0, 0);

        // fairness with both requesters continuously valid
        for (int i = 0; i < 4; i++)
            run_op(1, 1, 16'd89, 16'd78, 16'(-50), 16'(-78), 0, 0, 0, 0);

        // timeout, then a normal operation, then stale done with backpressure
        run_op(1, 0, 16'd7, 16'd9, 16'd0, 16'd0, 3, 1, 0, 0);
        run_op(0, 1, 16'd0, 16'd0, 16'd300, 16'(-7), 4, 0, 0, 0);
        run_op(1, 0, 16'd123, 16'd45, 16'd0, 16'd0, 5, 0, 1, 10);
        // completion and timeout in the same BUSY cycle
        run_op(0, 1, 16'd0, 16'd0, 16'd11, 16'd13, TO - 2, 0, 0, 1);

        for (int i = 0; i < 30; i++) begin
            int unsigned sel;
            sel = $urandom_range(1, 3);
            run_op(sel[0], sel[1], 16'($urandom()), 16'($urandom()), 16'($urandom()),
                   16'($urandom()), $urandom_range(0, TO - 2), 0, 0, $urandom_range(0, 3));
        end

        // reset while BUSY, with the pointer favouring requester 1 beforehand
        run_op(1, 0, 16'd3, 16'd4, 16'd0, 16'd0, 1, 0, 0, 0);
        @(negedge clk);
        m_lat = 6; m_tie_low = 0; m_stale = 0;
        req1_valid = 1'b1; req1_a = 16'd21; req1_b = 16'd2;
        repeat (2) @(negedge clk);
        #1;
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        rst = 1'b0;
        prio = 0;
        run_op(1, 1, 16'd6, 16'd7, 16'd8, 16'd9, 2, 0, 0, 0);
        run_op(0, 1, 16'd0, 16'd0, 16'd8, 16'd9, 2, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, maximum cycles spent in BUSY waiting for the multiplier's done before an error response is returned (legal range 2..255).
REQ-002 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: req0_valid / req1_valid  in  1  requester k presents an operand pair.
REQ-005 Port: req0_ready / req1_ready  out  1  requester k's operand pair is accepted this cycle.
REQ-006 Port: req0_a, req0_b, req1_a, req1_b  in  16  signed operands of requester k.
REQ-007 Port: resp0_valid / resp1_valid  out  1  a result is pending for requester k.
REQ-008 Port: resp0_ready / resp1_ready  in  1  requester k takes the result.
REQ-009 Port: resp_data  out  32  signed product, shared by both responders.
REQ-010 Port: resp_err  out  1  the pending response timed out; resp_data is 0.
REQ-011 Port: mul_in1, mul_in2  out  16  operands to the multiplier.
REQ-012 Port: mul_start  out  1  one-cycle start pulse to the multiplier.
REQ-013 Port: mul_out  in  32  multiplier product.
REQ-014 Port: mul_done  in  1  multiplier completion, level.
REQ-015 Port: busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, START, BUSY, RESP; one state per cycle unless a state below says it holds.
REQ-017 IDLE, requesters valid:
- Exactly one valid: that requester is granted.
- Both valid: the round-robin priority pointer picks the grant.
- Granted reqk_ready is asserted combinationally in the same cycle.
- Operands are latched and the owner id is recorded; next state is START.
REQ-018 reqk_ready is asserted only in IDLE and for at most one k per cycle.
REQ-019 START: mul_start=1 for exactly one cycle, then BUSY.
- mul_in1 and mul_in2 hold the latched operands from START until the response is taken.
REQ-020 BUSY, completion:
- Completion is a rising edge of mul_done (mul_done=1 and its registered copy was 0).
- A level high on mul_done that is left over from a previous operation is ignored.
- On completion, mul_out is captured into resp_data, resp_err=0, next state is RESP.
REQ-021 BUSY, timeout:
- A cycle counter clears on entry to BUSY.
- When the counter reaches TIMEOUT_CYCLES-1 with no completion: resp_data=0, resp_err=1, next state is RESP.
- If completion and timeout occur in the same cycle, completion wins.
REQ-022 RESP: respk_valid=1 for the owner only, and resp_data/resp_err are held stable.
- The state holds until respk_ready=1; on that cycle the next state is IDLE.
- Ready from the non-owner has no effect.
REQ-023 The priority pointer updates when a response is taken: it points to the requester that was not the owner.
- req_valid and req operands are ignored in START, BUSY and RESP.
REQ-024 Latency:
- Accept at cycle T, mul_start at T+1, completion edge at cycle D, respk_valid from D+1.
- Minimum cycles between back-to-back accepts: 4 plus the multiplier latency.
REQ-025 Requirements on requesters: a requester holds valid and its operands stable until ready.
- The block does not check this; an operand change before ready is sampled as-is at the accept cycle.

Reset
REQ-026 rst asynchronously forces the reset state, including mid-operation in any state:
- State IDLE, priority pointer to requester 0.
- All outputs 0, with no mul_start pulse.
- Counter, owner, latched operands, resp_data and resp_err all 0.
REQ-027 On the first edge after rst deasserts, the block behaves as IDLE with fresh arbitration.

Verification
REQ-028 Single request: req0 5 x -3 -> req0_ready at T, mul_start at T+1, resp0_valid with resp_data=-15 and resp_err=0, resp1_valid never set.
REQ-029 Simultaneous requests after reset: req0 -32768 x -1, req1 32767 x 2 -> req0 served first (resp_data=32768), then req1 (65534).
REQ-030 Fairness: both valid continuously for 4 operations -> grant order 0,1,0,1; results 89x78=6942 and -50x-78=3900 correct per owner.
REQ-031 Timeout: mul_done tied low, TIMEOUT_CYCLES=8 -> RESP after exactly 8 BUSY cycles, resp_err=1, resp_data=0; the next request is served normally.
REQ-032 Stale done and response backpressure: mul_done held high entering START -> no capture until a fresh rising edge; resp0_ready low for 10 cycles -> resp0_valid and data stable, no new accept.
REQ-033 Reset mid-BUSY: rst pulsed -> all outputs 0 immediately (asynchronously); after release a pending req1 is granted only if req0 is not valid.
